// File: rtl/pueo_mode1_pkg.sv
// Shared types and constants for the mode1 register-access packet receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pueo_mode1_pkg;

    // Packet is B0 {wr, addr}, B1..B4 data MSB first, B5 checksum.
    localparam int          PKT_LEN  = 6;
    localparam logic [2:0]  IDX_B0   = 3'd0;
    localparam logic [2:0]  IDX_DATA = 3'd1;
    localparam logic [2:0]  IDX_CSUM = 3'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DISCARD = 2'd2
    } coll_state_t;

    typedef struct packed {
        logic [6:0]  addr;
        logic        wr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/pueo_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Latency: count reflects an inc pulse on the following cycle.
// Backpressure: none; one increment per cycle at most.
module pueo_sat_counter #(
    parameter int W = 8
) (
    input  logic         sysclk_i,
    input  logic         sysrst_n_i,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc, hold once every bit is set.
    always_ff @(posedge sysclk_i) begin
        if (!sysrst_n_i) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pueo_mode1_packet_rx.sv
// Assembles 6-byte mode1 register packets, validates framing/checksum, issues one request at a time.
// Latency: req_valid_o rises one cycle after the B5 byte; error counts update one cycle after the byte.
// Backpressure: upstream cannot stall; good packets arriving while a request is stuck are dropped and
// counted in err_ovf. Build option PUEO_MODE1_CHECKSUM_EN enables checksum checking and err_csum.
module pueo_mode1_packet_rx
    import pueo_mode1_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 sysclk_i,
    input  logic                 sysrst_n_i,
    input  logic                 cmdproc_rst_i,
    input  logic [7:0]           cmdproc_tdata,
    input  logic                 cmdproc_tvalid,
    input  logic                 cmdproc_tlast,
    output logic [6:0]           req_addr_o,
    output logic                 req_wr_o,
    output logic [31:0]          req_wdata_o,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [ERR_CNT_W-1:0] err_short_o,
    output logic [ERR_CNT_W-1:0] err_long_o,
    output logic [ERR_CNT_W-1:0] err_csum_o,
    output logic [ERR_CNT_W-1:0] err_ovf_o
);

    coll_state_t state_q;
    logic [2:0]  idx_q;
    logic [7:0]  b0_q;
    logic [31:0] data_q;
    req_t        req_q;
    req_t        req_nxt;
    logic        req_vld_q;

    logic        byte_vld;
    logic        complete;
    logic        csum_ok;
    logic        pkt_good;
    logic        req_load;
    logic        short_evt;
    logic        long_evt;
    logic        csum_evt;
    logic        ovf_evt;

`ifdef PUEO_MODE1_CHECKSUM_EN
    logic [7:0]  sum_q;
    logic [7:0]  sum_nxt;
`endif

    // Decode the current byte into framing events and the request-load decision.
    always_comb begin
        byte_vld  = cmdproc_tvalid & ~cmdproc_rst_i;
        short_evt = 1'b0;
        long_evt  = 1'b0;
        complete  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                short_evt = byte_vld & cmdproc_tlast;
            end
            ST_COLLECT: begin
                if (byte_vld) begin
                    if (idx_q == IDX_CSUM) begin
                        complete = cmdproc_tlast;
                        long_evt = ~cmdproc_tlast;
                    end else begin
                        short_evt = cmdproc_tlast;
                    end
                end
            end
            default: ;
        endcase

`ifdef PUEO_MODE1_CHECKSUM_EN
        sum_nxt = sum_q + cmdproc_tdata;
        csum_ok = (sum_nxt == 8'h00);
`else
        csum_ok = 1'b1;
`endif

        pkt_good = complete & csum_ok;
        csum_evt = complete & ~csum_ok;
        req_load = pkt_good & (~req_vld_q | req_ready_i);
        ovf_evt  = pkt_good & ~req_load;

        req_nxt.addr  = b0_q[6:0];
        req_nxt.wr    = b0_q[7];
        req_nxt.wdata = b0_q[7] ? data_q : 32'h0;
    end

    // Collector FSM: capture B0 and data bytes, track index (and running sum when checked).
    always_ff @(posedge sysclk_i) begin
        if (!sysrst_n_i) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_B0;
            b0_q    <= 8'h00;
            data_q  <= 32'h0;
`ifdef PUEO_MODE1_CHECKSUM_EN
            sum_q   <= 8'h00;
`endif
        end else if (cmdproc_rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_B0;
`ifdef PUEO_MODE1_CHECKSUM_EN
            sum_q   <= 8'h00;
`endif
        end else if (cmdproc_tvalid) begin
            case (state_q)
                ST_IDLE: begin
                    b0_q <= cmdproc_tdata;
                    if (cmdproc_tlast) begin
                        idx_q <= IDX_B0;
`ifdef PUEO_MODE1_CHECKSUM_EN
                        sum_q <= 8'h00;
`endif
                    end else begin
                        idx_q   <= IDX_DATA;
                        state_q <= ST_COLLECT;
`ifdef PUEO_MODE1_CHECKSUM_EN
                        sum_q   <= cmdproc_tdata;
`endif
                    end
                end
                ST_COLLECT: begin
                    if (idx_q == IDX_CSUM) begin
                        idx_q   <= IDX_B0;
                        state_q <= cmdproc_tlast ? ST_IDLE : ST_DISCARD;
`ifdef PUEO_MODE1_CHECKSUM_EN
                        sum_q   <= 8'h00;
`endif
                    end else begin
                        data_q <= {data_q[23:0], cmdproc_tdata};
                        if (cmdproc_tlast) begin
                            idx_q   <= IDX_B0;
                            state_q <= ST_IDLE;
`ifdef PUEO_MODE1_CHECKSUM_EN
                            sum_q   <= 8'h00;
`endif
                        end else begin
                            idx_q <= idx_q + 3'd1;
`ifdef PUEO_MODE1_CHECKSUM_EN
                            sum_q <= sum_nxt;
`endif
                        end
                    end
                end
                ST_DISCARD: begin
                    if (cmdproc_tlast) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= IDX_B0;
                end
            endcase
        end
    end

    // Request register: load on a good packet when free or being accepted, clear on acceptance.
    always_ff @(posedge sysclk_i) begin
        if (!sysrst_n_i) begin
            req_q     <= '0;
            req_vld_q <= 1'b0;
        end else if (req_load) begin
            req_q     <= req_nxt;
            req_vld_q <= 1'b1;
        end else if (req_vld_q && req_ready_i) begin
            req_vld_q <= 1'b0;
        end
    end

    assign req_addr_o  = req_q.addr;
    assign req_wr_o    = req_q.wr;
    assign req_wdata_o = req_q.wdata;
    assign req_valid_o = req_vld_q;

    pueo_sat_counter #(.W(ERR_CNT_W)) u_cnt_short (
        .sysclk_i   (sysclk_i),
        .sysrst_n_i (sysrst_n_i),
        .inc        (short_evt),
        .cnt        (err_short_o)
    );

    pueo_sat_counter #(.W(ERR_CNT_W)) u_cnt_long (
        .sysclk_i   (sysclk_i),
        .sysrst_n_i (sysrst_n_i),
        .inc        (long_evt),
        .cnt        (err_long_o)
    );

    // Without checksum checking csum_evt is constant 0, so this counter stays at 0.
    pueo_sat_counter #(.W(ERR_CNT_W)) u_cnt_csum (
        .sysclk_i   (sysclk_i),
        .sysrst_n_i (sysrst_n_i),
        .inc        (csum_evt),
        .cnt        (err_csum_o)
    );

    pueo_sat_counter #(.W(ERR_CNT_W)) u_cnt_ovf (
        .sysclk_i   (sysclk_i),
        .sysrst_n_i (sysrst_n_i),
        .inc        (ovf_evt),
        .cnt        (err_ovf_o)
    );

endmodule

// File: doc/pueo_mode1_packet_rx.md
# pueo_mode1_packet_rx

Consumes the byte stream produced by the command decoder's mode1 path (data, valid, last, plus the mode1 reset strobe) and assembles fixed 6-byte register-access packets. It validates framing and checksum and presents one register request at a time to the downstream register bus with a valid/ready handshake. The upstream stream has no backpressure, so the block must absorb or drop traffic itself and count every loss.

## Interface
Parameters:
- ERR_CNT_W, 8, width of each saturating error counter.

Ports:
- sysclk_i  in  1  system clock; all logic is on its rising edge.
- sysrst_n_i  in  1  synchronous, active-low reset.
- cmdproc_rst_i  in  1  mode1 reset strobe from the decoder (one cycle).
- cmdproc_tdata  in  8  packet byte.
- cmdproc_tvalid  in  1  byte strobe. Never more than one byte per cycle.
- cmdproc_tlast  in  1  qualifies the final byte of a packet.
- req_addr_o  out  7  register address.
- req_wr_o  out  1  1 = write, 0 = read.
- req_wdata_o  out  32  write data (zero for reads).
- req_valid_o  out  1  request pending.
- req_ready_i  in  1  downstream accepts the request when both valid and ready are high.
- err_short_o  out  ERR_CNT_W  count of packets with fewer than 6 bytes.
- err_long_o  out  ERR_CNT_W  count of packets with more than 6 bytes.
- err_csum_o  out  ERR_CNT_W  count of checksum failures.
- err_ovf_o  out  ERR_CNT_W  count of good packets dropped because a request was already pending.

## Operation
- Packet format, in byte order:
  - B0 = {wr, addr[6:0]}.
  - B1..B4 = data[31:24], [23:16], [15:8], [7:0].
  - B5 = checksum. B5 must carry tlast.
- Checksum rule: B0+…+B5 mod 256 == 0.
- Collector state machine: IDLE, COLLECT, DISCARD. A 3-bit byte index runs 0..5, and an 8-bit running sum is kept.
  - IDLE: a valid byte stores B0, sets index=1 and goes to COLLECT. If that byte also has tlast, it is a short packet: increment err_short and stay in IDLE.
  - COLLECT: each valid byte is stored at the current index and the index increments.
    - tlast with index<5: increment err_short, go to IDLE.
    - index==5 with tlast: the packet is complete. Evaluate the checksum, go to IDLE.
    - index==5 without tlast: increment err_long, go to DISCARD.
  - DISCARD: drop bytes until a tlast byte arrives, then go to IDLE. A packet counts in err_long once, however long it is.
- Complete packet with a good checksum:
  - If req_valid_o is low, or req_ready_i is high in the same cycle, load the request register and hold req_valid_o high.
  - Otherwise drop the packet and increment err_ovf. The pending request is not modified.
- Bad checksum: increment err_csum, no request is issued.
- Reads drive req_wdata_o to 0. Data bytes are captured but not forwarded.
- The request register holds its contents stable while valid is high and ready is low.
- cmdproc_rst_i:
  - Forces the collector to IDLE and clears the index and running sum.
  - Does not touch the pending request or the counters.
  - A byte arriving in the same cycle is discarded.
- Counters saturate at all-ones and never wrap.
- When two error conditions fall in the same cycle, each increments its own counter.

## Timing
- Reset values: every output is 0, the collector is in IDLE, the index and sum are 0.
- Latency: req_valid_o rises on the cycle after the B5 byte cycle.
- Acceptance: a request is accepted on the cycle where valid and ready are both high. req_valid_o falls on the next cycle unless a new packet completes in that same acceptance cycle, in which case it stays high with the new contents.
- Error counters update on the cycle after the offending byte.
- Reset mid-packet leaves no residue. The first valid byte after reset is treated as B0.

## Configuration
- PUEO_MODE1_CHECKSUM_EN defined: the checksum is checked as above and err_csum_o counts failures.
- PUEO_MODE1_CHECKSUM_EN undefined:
  - B5 is still required for framing, but its value is ignored.
  - err_csum_o is tied to 0 and the sum logic is removed.

## Structure
- Package pueo_mode1_pkg holds:
  - the collector state enum;
  - the packet length constant (6) and byte index constants;
  - a packed request struct (addr, wr, wdata).
- One sub-module: pueo_sat_counter (parameter width, inputs increment and reset), instantiated four times.

## Test plan
- Write 0x85, data 0xDEADBEEF, valid checksum -> one request with addr=0x05, wr=1, wdata=0xDEADBEEF. req_valid_o rises 1 cycle after B5 and holds until ready.
- Read packet for addr 0x12 with ready held low, then a second good packet -> the first request is retained, err_ovf=1. Raise ready -> the first request is accepted and valid drops.
- 4-byte packet ending in tlast -> err_short=1, no request. An 8-byte packet -> err_long=1 and the following good packet decodes correctly.
- Checksum off by 1 -> err_csum=1, no request. Without PUEO_MODE1_CHECKSUM_EN -> a request is issued and err_csum=0.
- cmdproc_rst_i after byte 3, then a full good packet -> exactly one correct request and no error counts.
- 300 short packets -> err_short saturates at 255. Assert sysrst_n_i low -> all outputs are 0.
